// File: rtl/serial_adder.sv
// Bit-serial adder: one bit per clock, LSB first, result latched at DONE.
// Optional SERIAL_ADDER_SUB_EN adds a sub port that turns the op into a-b.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             hz100,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [IW-1:0]    idx_q;
    logic             c_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             busy_q;
    logic             done_q;

    logic             s_d;
    logic             c_d;
    logic             accept;
    logic [WIDTH-1:0] b_cap;
    logic             c_cap;
    logic             last;

    // Subtraction reuses the adder: a + ~b + 1.
`ifdef SERIAL_ADDER_SUB_EN
    assign b_cap = sub ? ~b : b;
    assign c_cap = sub ? 1'b1 : cin;
`else
    assign b_cap = b;
    assign c_cap = cin;
`endif

    assign accept = start && (state_q != RUN);
    assign last   = (idx_q == IW'(WIDTH - 1));
    assign s_d    = a_q[idx_q] ^ b_q[idx_q] ^ c_q;
    assign c_d    = (a_q[idx_q] & b_q[idx_q])
                  | (a_q[idx_q] & c_q)
                  | (b_q[idx_q] & c_q);

    always_comb begin
        res_d        = res_q;
        res_d[idx_q] = s_d;
    end

    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            c_q     <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                a_q     <= a;
                b_q     <= b_cap;
                c_q     <= c_cap;
                idx_q   <= '0;
                state_q <= RUN;
                busy_q  <= 1'b1;
            end else begin
                unique case (state_q)
                    RUN: begin
                        res_q <= res_d;
                        c_q   <= c_d;
                        if (last) begin
                            sum_q   <= res_d;
                            cout_q  <= c_d;
                            ovf_q   <= c_q ^ c_d;
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q <= idx_q + IW'(1);
                        end
                    end
                    DONE:    state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule
